// File: rtl/async_up_down_counter.sv
// 4-bit up/down counter made of four JK cells sharing J/K controls.
// Every cell is clocked by clk; ripple carry is emulated by per-cell toggle enables.
module async_up_down_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       j,
  input  logic       k,
  input  logic       s,
  output logic [3:0] q,
  output logic [3:0] qbar
);

  logic [3:0] t;
  logic [3:0] q_next;

  // A cell toggles when all lower cells are 1 (counting up) or all are 0 (counting down).
  always_comb begin
    t[0] = 1'b1;
    t[1] = s ? q[0]    : ~q[0];
    t[2] = s ? &q[1:0] : ~|q[1:0];
    t[3] = s ? &q[2:0] : ~|q[2:0];
  end

  always_comb begin
    q_next = q;
    unique case ({j, k})
      2'b00: q_next = q;
      2'b01: q_next = '0;
      2'b10: q_next = '1;
      2'b11: q_next = q ^ t;
      default: q_next = q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      q <= q_next;
    end
  end

  assign qbar = ~q;

endmodule

// File: tb/tb_async_up_down_counter.sv
// Self-checking bench: directed test-plan steps followed by random steps,
// all compared against an arithmetic reference model.
module tb_async_up_down_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       j = 1'b0;
  logic       k = 1'b0;
  logic       s = 1'b1;
  logic [3:0] q;
  logic [3:0] qbar;

  int unsigned passed = 0;
  int unsigned total = 0;
  int          model = 0;

  async_up_down_counter dut (
    .clk  (clk),
    .rst_n(rst_n),
    .j    (j),
    .k    (k),
    .s    (s),
    .q    (q),
    .qbar (qbar)
  );

  always #5 clk = ~clk;

  task automatic step(input logic rn, input logic jj, input logic kk, input logic ss,
                      input string tag);
    logic [3:0] exp_q;
    logic [3:0] exp_qbar;
    @(negedge clk);
    rst_n = rn;
    j     = jj;
    k     = kk;
    s     = ss;
    @(posedge clk);
    #1;
    if (!rn)              model = 0;
    else if (!jj && kk)   model = 0;
    else if (jj && !kk)   model = 15;
    else if (jj && kk)    model = ss ? (model + 1) % 16 : (model + 15) % 16;
    exp_q    = 4'(model);
    exp_qbar = 4'(15 - model);
    total++;
    assert (q === exp_q) passed++;
    else $error("FAIL %s q: got %b expected %b", tag, q, exp_q);
    total++;
    assert (qbar === exp_qbar) passed++;
    else $error("FAIL %s qbar: got %b expected %b", tag, qbar, exp_qbar);
  endtask

  initial begin
    // reset with counting requested: reset must win
    step(1'b0, 1'b1, 1'b1, 1'b1, "reset");
    repeat (3) step(1'b0, 1'b1, 1'b1, 1'b1, "reset_hold");

    // count up 1..15 then wrap to 0
    repeat (15) step(1'b1, 1'b1, 1'b1, 1'b1, "count_up");
    step(1'b1, 1'b1, 1'b1, 1'b1, "up_wrap");

    // up to 4, then down through 0 with wrap to 15, 14, then up again
    repeat (4) step(1'b1, 1'b1, 1'b1, 1'b1, "up_to_4");
    repeat (4) step(1'b1, 1'b1, 1'b1, 1'b0, "count_down");
    step(1'b1, 1'b1, 1'b1, 1'b0, "down_wrap");
    step(1'b1, 1'b1, 1'b1, 1'b0, "down_14");
    step(1'b1, 1'b1, 1'b1, 1'b1, "dir_up_15");
    step(1'b1, 1'b1, 1'b1, 1'b1, "dir_up_wrap");

    // reach 0101, hold, set, clear
    repeat (5) step(1'b1, 1'b1, 1'b1, 1'b1, "up_to_5");
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, "hold");
    step(1'b1, 1'b1, 1'b0, 1'b0, "set_all");
    step(1'b1, 1'b0, 1'b1, 1'b1, "clear_all");

    // reset mid-count at 1001, then restart
    repeat (9) step(1'b1, 1'b1, 1'b1, 1'b1, "up_to_9");
    step(1'b0, 1'b1, 1'b1, 1'b1, "mid_reset");
    step(1'b1, 1'b1, 1'b1, 1'b1, "after_reset");

    // simultaneous events
    step(1'b0, 1'b1, 1'b0, 1'b1, "reset_vs_set");
    step(1'b1, 1'b0, 1'b0, 1'b1, "hold_before_toggle");
    step(1'b1, 1'b1, 1'b1, 1'b0, "s_sampled_down");
    step(1'b1, 1'b0, 1'b0, 1'b1, "hold_again");
    step(1'b1, 1'b1, 1'b1, 1'b1, "s_sampled_up");

    // random stimulus, reset asserted rarely
    for (int n = 0; n < 300; n++) begin
      step(($urandom_range(0, 15) != 0), 1'($urandom), 1'($urandom), 1'($urandom), "random");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
